// File: rtl/countdown_timer_pkg.sv
// Shared timer/counter definitions: FSM state encodings and default datapath width.
// Imported by countdown_timer, countdown_core and sibling counter blocks.
package countdown_timer_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/countdown_core.sv
// Countdown datapath: count register with clear/load/reload/decrement mux and terminal (count==1) flag.
// Single-cycle update; priority clr > load > reload > dec; no wrap below zero in normal use.
module countdown_core
  import countdown_timer_pkg::*;
#(
  parameter int w = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [w-1:0] load_value,
  input  logic         reload,
  input  logic [w-1:0] reload_value,
  input  logic         dec,
  output logic [w-1:0] count,
  output logic         term
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (reload) begin
      count <= reload_value;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign term = (count == {{(w-1){1'b0}}, 1'b1});

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-cycle registered done pulse on expiry; optional periodic
// mode under COUNTDOWN_AUTO_RELOAD_EN. Priority rst > stop > load > en.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int w = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [w-1:0] load_value,
  input  logic         en,
  input  logic         stop,
  output logic [w-1:0] count,
  output logic         busy,
  output logic         done
);

  state_t       state;
  logic         term;
  logic         core_load;
  logic         core_dec;
  logic         core_reload;
  logic [w-1:0] reload_value;

  assign core_load = load & ~stop;
  assign core_dec  = (state == ST_RUN) & en & ~stop & ~load;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [w-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
    end else if (core_load) begin
      reload_q <= load_value;
    end
  end

  assign reload_value = reload_q;
  assign core_reload  = core_dec & term;
`else
  assign reload_value = '0;
  assign core_reload  = 1'b0;
`endif

  countdown_core #(.w(w)) u_core (
    .clk          (clk),
    .rst          (rst),
    .clr          (stop),
    .load         (core_load),
    .load_value   (load_value),
    .reload       (core_reload),
    .reload_value (reload_value),
    .dec          (core_dec),
    .count        (count),
    .term         (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (load) begin
        // A zero-length interval expires immediately without entering RUN.
        if (load_value != '0) begin
          state <= ST_RUN;
          busy  <= 1'b1;
        end else begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (state == ST_RUN && en && term) begin
        done <= 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        state <= ST_IDLE;
        busy  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed literal scenarios plus randomized traffic checked every cycle
// against a behavioural model; expectations follow COUNTDOWN_AUTO_RELOAD_EN when defined.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       en = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model state: what the outputs must be after the latest edge.
  int m_cnt  = 0;
  bit m_run  = 0;
  bit m_done = 0;
  int m_rel  = 0;

  countdown_timer #(.w(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .en         (en),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_run = 0; m_done = 0; m_rel = 0;
    end else begin
      m_done = 0;
      if (stop) begin
        m_cnt = 0; m_run = 0;
      end else if (load) begin
        m_rel = int'(load_value);
        if (load_value == 0) begin
          m_cnt = 0; m_run = 0; m_done = 1;
        end else begin
          m_cnt = int'(load_value); m_run = 1;
        end
      end else if (m_run && en) begin
        if (m_cnt == 1) begin
          m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          m_cnt = m_rel;
`else
          m_cnt = 0; m_run = 0;
`endif
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(count), m_cnt);
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_done", int'(done), int'(m_done));
    end
  end

  task automatic step(input bit r, input bit ld, input int lv, input bit e, input bit s);
    @(negedge clk);
    rst = r; load = ld; load_value = 8'(lv); en = e; stop = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input int c, input int b, input int d);
    chk({name, "_count"}, int'(count), c);
    chk({name, "_busy"}, int'(busy), b);
    chk({name, "_done"}, int'(done), d);
  endtask

  initial begin
    int ec;
    int ed;
    step(1, 0, 0, 0, 0);
    // Reset dominates load and en.
    step(1, 1, 9, 1, 0);
    expect3("rst_dom", 0, 0, 0);

    // Load 5 with en high: load wins, then 5,4,3,2,1,0.
    step(0, 1, 5, 1, 0);
    expect3("l5_load", 5, 1, 0);
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 0, 1, 0);
      expect3("l5_run", i, 1, 0);
    end
    step(0, 0, 0, 1, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    expect3("l5_expire", 5, 1, 1);
    step(0, 0, 0, 0, 1);
`else
    expect3("l5_expire", 0, 0, 1);
    step(0, 0, 0, 1, 0);
    expect3("l5_after", 0, 0, 0);
`endif

    // Load 4, en pattern 1,0,0,1,1,1.
    step(0, 1, 4, 0, 0);
    step(0, 0, 0, 1, 0); expect3("l4_e1", 3, 1, 0);
    step(0, 0, 0, 0, 0); expect3("l4_p1", 3, 1, 0);
    step(0, 0, 0, 0, 0); expect3("l4_p2", 3, 1, 0);
    step(0, 0, 0, 1, 0); expect3("l4_e2", 2, 1, 0);
    step(0, 0, 0, 1, 0); expect3("l4_e3", 1, 1, 0);
    step(0, 0, 0, 1, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    expect3("l4_e4", 4, 1, 1);
`else
    expect3("l4_e4", 0, 0, 1);
`endif
    step(0, 0, 0, 0, 1);
    expect3("stop_idle", 0, 0, 0);

    // Zero-length interval.
    step(0, 1, 0, 1, 0); expect3("l0", 0, 0, 1);
    step(0, 0, 0, 1, 0); expect3("l0_after", 0, 0, 0);

    // Stop mid-interval.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0); expect3("stop_pre", 2, 1, 0);
    step(0, 0, 0, 1, 1); expect3("stop", 0, 0, 0);
    step(0, 0, 0, 1, 0); expect3("stop_after", 0, 0, 0);

    // Restart at count 1 suppresses the pending expiry.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0); expect3("rl_pre", 1, 1, 0);
    step(0, 1, 7, 1, 0); expect3("rl", 7, 1, 0);
    step(0, 0, 0, 1, 0); expect3("rl_next", 6, 1, 0);
    step(0, 0, 0, 0, 1);

    // Full-scale value.
    step(0, 1, 255, 0, 0); expect3("l255", 255, 1, 0);
    step(0, 0, 0, 1, 0);   expect3("l255_dec", 254, 1, 0);
    step(0, 0, 0, 0, 1);

    // Load 3 and hold en for 10 cycles.
    step(0, 1, 3, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0, 1, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      ec = (i % 3 == 0) ? 3 : 3 - (i % 3);
      ed = (i % 3 == 0) ? 1 : 0;
`else
      ec = (i < 3) ? 3 - i : 0;
      ed = (i == 3) ? 1 : 0;
`endif
      chk("per_count", int'(count), ec);
      chk("per_done", int'(done), ed);
    end

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      int lv;
      sel = int'($urandom_range(0, 9));
      lv = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(1, 6));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), lv,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end

    step(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
